// File: rtl/fifo_read_pkg.sv
// fifo_read_pkg
//   Shared definitions for the FIFO read controller: FSM state encoding,
//   skid buffer depth and the width used for the skid occupancy count.
package fifo_read_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FULL   = 2'd2
  } state_t;

  localparam int SKID_DEPTH = 2;
  // Occupancy ranges 0..SKID_DEPTH, so two bits are enough.
  localparam int OCC_W = 2;

endpackage

// File: rtl/fifo_read_skid.sv
// fifo_read_skid
//   Two-entry skid buffer in FIFO order. Entry 0 is always the oldest and
//   drives the head outputs, so the head is stable while nothing is popped.
//   Optional macro FIFO_READ_PARITY_EN: stores the XOR parity of each entry
//   next to its data and presents it as head_parity.
// Ports:
//   clk_read    clock
//   rst         synchronous active-low reset
//   push        write push_data behind the current entries
//   push_data   incoming data
//   pop         drop the oldest entry
//   occupancy   number of valid entries (0..SKID_DEPTH)
//   head_data   oldest entry
//   head_parity parity of the oldest entry (FIFO_READ_PARITY_EN only)
module fifo_read_skid
  import fifo_read_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_read,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [OCC_W-1:0]  occupancy,
`ifdef FIFO_READ_PARITY_EN
  output logic              head_parity,
`endif
  output logic [DATA_W-1:0] head_data
);

`ifdef FIFO_READ_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;
  logic [ENTRY_W-1:0] push_entry;
  assign push_entry  = {^push_data, push_data};
`else
  localparam int ENTRY_W = DATA_W;
  logic [ENTRY_W-1:0] push_entry;
  assign push_entry  = push_data;
`endif

  logic [ENTRY_W-1:0] mem [SKID_DEPTH];

  assign head_data = mem[0][DATA_W-1:0];
`ifdef FIFO_READ_PARITY_EN
  assign head_parity = mem[0][DATA_W];
`endif

  // The controller never pushes into a full buffer without a pop in the
  // same cycle, and never pops an empty one.
  always_ff @(posedge clk_read) begin
    if (!rst) begin
      occupancy <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          mem[occupancy[0]] <= push_entry;
          occupancy         <= occupancy + 2'd1;
        end
        2'b01: begin
          mem[0]    <= mem[1];
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (occupancy == 2'(SKID_DEPTH)) begin
            mem[0] <= mem[1];
            mem[1] <= push_entry;
          end else begin
            mem[0] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
//   Drains a FIFO with one-cycle registered read data into a valid/ready
//   stream through a two-entry skid buffer, counting completed transfers.
//   Optional macro FIFO_READ_PARITY_EN adds output m_parity (XOR of m_data).
// Ports:
//   clk_read          clock
//   rst               synchronous active-low reset
//   fifo_data_out     FIFO read data, valid the cycle after a strobe
//   fifo_empty        FIFO empty flag
//   fifo_read_enable  FIFO read strobe
//   m_data/m_valid    stream output, m_ready downstream accept
//   enable            drain enable (gates new reads only)
//   xfer_count        completed transfers, wraps
//   busy              read in flight or data buffered
//
//   state  | meaning
//   IDLE   | skid empty, no read in flight
//   STREAM | one entry buffered, or a read in flight
//   FULL   | two entries buffered, nothing in flight
module fifo_read_ctrl
  import fifo_read_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_read,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              fifo_read_enable,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              enable,
  output logic [CNT_W-1:0]  xfer_count,
`ifdef FIFO_READ_PARITY_EN
  output logic              m_parity,
`endif
  output logic              busy
);

  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(SKID_DEPTH);

  state_t           state_q, state_d;
  logic             in_flight_q;
  logic             run_q;
  logic [OCC_W-1:0] occupancy;
  logic [OCC_W-1:0] occ_after;
  logic [OCC_W-1:0] occ_next;
  logic             xfer;

  fifo_read_skid #(.DATA_W(DATA_W)) u_skid (
    .clk_read  (clk_read),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data (fifo_data_out),
    .pop       (xfer),
    .occupancy (occupancy),
`ifdef FIFO_READ_PARITY_EN
    .head_parity (m_parity),
`endif
    .head_data (m_data)
  );

  assign m_valid   = (occupancy != '0);
  assign xfer      = m_valid & m_ready;
  assign occ_after = occupancy - {1'b0, xfer};
  // Entries present at the start of next cycle; a new strobe is only
  // allowed when its data will still have a free slot on capture.
  assign occ_next  = occ_after + {1'b0, in_flight_q};

  // run_q holds reads off for the first cycle after reset release; the
  // combinational rst term keeps the strobe low while reset is asserted.
  assign fifo_read_enable = rst & run_q & enable & ~fifo_empty & (occ_next < DEPTH);

  always_comb begin
    state_d = STREAM;
    if (occ_next == DEPTH)                          state_d = FULL;
    else if (occ_next == '0 && !fifo_read_enable)   state_d = IDLE;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk_read) begin
    if (!rst) begin
      state_q     <= IDLE;
      in_flight_q <= 1'b0;
      run_q       <= 1'b0;
      xfer_count  <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fifo_read_enable;
      run_q       <= 1'b1;
      if (xfer) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  logic        clk_read = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_read_enable;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] xfer_count;
  logic        busy;
`ifdef FIFO_READ_PARITY_EN
  logic        m_parity;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_q [$];   // contents of the FIFO feeding the DUT
  logic [7:0] exp_q  [$];   // bytes popped from the FIFO, in delivery order

  fifo_read_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
    .clk_read         (clk_read),
    .rst              (rst),
    .fifo_data_out    (fifo_data_out),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .enable           (enable),
    .xfer_count       (xfer_count),
`ifdef FIFO_READ_PARITY_EN
    .m_parity         (m_parity),
`endif
    .busy             (busy)
  );

  always #5 clk_read = ~clk_read;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle of the FIFO model: pop on the strobe seen mid-cycle,
  // present the popped byte just after the edge (registered read data).
  task automatic step(output logic strobe);
    logic [7:0] d;
    d = fifo_data_out;
    @(negedge clk_read);
    strobe = fifo_read_enable;
    if (strobe && fifo_q.size() > 0) begin
      d = fifo_q.pop_front();
      exp_q.push_back(d);
    end
    @(posedge clk_read);
    #1;
    fifo_data_out = d;
    fifo_empty    = (fifo_q.size() == 0);
  endtask

  task automatic steps(input int n);
    logic s;
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic drain(input string name, input int budget);
    logic s;
    int   n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step(s);
      n++;
    end
    steps(2);
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      check({name, "_timeout"}, 32'(fifo_q.size() + exp_q.size()), 32'd0);
    end
  endtask

  // Monitor: reference model of the controller in terms of bytes buffered,
  // bytes in flight and transfers made, checked every cycle mid-period.
  initial begin
    int         occ_m;
    logic       infl_m;
    logic [15:0] cnt_m;
    logic       rst_prev;
    logic       edge_rst;
    logic       exp_valid, exp_xfer, exp_rd;
    logic       hold_prev;
    logic [7:0] data_prev;
    logic [7:0] e;
    occ_m = 0; infl_m = 1'b0; cnt_m = '0; rst_prev = 1'b0;
    hold_prev = 1'b0; data_prev = '0;
    forever begin
      @(negedge clk_read);
      edge_rst = rst_prev;   // rst value sampled by the edge just past
      rst_prev = rst;
      if (!edge_rst) begin
        occ_m = 0; infl_m = 1'b0; cnt_m = '0; hold_prev = 1'b0;
        exp_q.delete();
        check("reset_m_data", 32'(m_data), 32'd0);
      end
      exp_valid = (occ_m > 0);
      exp_xfer  = exp_valid && m_ready;
      exp_rd    = edge_rst && enable && !fifo_empty &&
                  ((occ_m - int'(exp_xfer) + int'(infl_m)) < 2);
      check("m_valid", 32'(m_valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_valid || infl_m));
      check("xfer_count", 32'(xfer_count), 32'(cnt_m));
      if (rst || !edge_rst)
        check("fifo_read_enable", 32'(fifo_read_enable), 32'(exp_rd));
      if (hold_prev && exp_valid)
        check("m_data_hold", 32'(m_data), 32'(data_prev));
      if (exp_xfer) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e));
`ifdef FIFO_READ_PARITY_EN
          check("m_parity", 32'(m_parity), 32'(^e));
`endif
        end
      end
      hold_prev = exp_valid && !m_ready;
      data_prev = m_data;
      occ_m  = occ_m - int'(exp_xfer) + int'(infl_m);
      infl_m = exp_rd;
      cnt_m  = cnt_m + 16'(exp_xfer);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int   n;

    // Reset with a loaded FIFO, then stream 0x01..0x10 at full rate.
    rst = 1'b0; enable = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    steps(2);
    rst = 1'b1;
    steps(19);
    check("stream_count", 32'(xfer_count), 32'd16);

    // Backpressure mid-stream.
    for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
    push(8'h07);
    push(8'h03);
    steps(4);
    m_ready = 1'b0;
    steps(10);
    check("bp_no_strobe", 32'(fifo_read_enable), 32'd0);
    check("bp_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    drain("bp_drain", 50);

    // Single-entry FIFO.
    push(8'hA5);
    steps(6);
    check("single_pop", 32'(fifo_q.size()), 32'd0);
    drain("single_drain", 10);

    // Enable dropped with a read in flight.
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    n = 0;
    s = 1'b0;
    while (!s && n < 10) begin
      step(s);
      n++;
    end
    check("enable_drop_strobe_seen", 32'(s), 32'd1);
    enable = 1'b0;
    steps(8);
    check("enable_drop_pops", 32'(fifo_q.size()), 32'd3);
    check("enable_drop_delivered", 32'(exp_q.size()), 32'd0);
    enable = 1'b1;
    drain("enable_drain", 20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) == 1;
      if (fifo_q.size() < 8 && $urandom_range(0, 9) < 3) push(8'($urandom));
      step(s);
    end
    enable = 1'b1; m_ready = 1'b1;
    drain("random_drain", 50);

    // Reset mid-operation with full skid, then counter wrap at full rate.
    for (int i = 0; i < 6; i++) push(8'($urandom));
    m_ready = 1'b0;
    steps(5);
    rst = 1'b0;
    steps(2);
    m_ready = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      while (fifo_q.size() < 4) push(8'($urandom));
      step(s);
    end
    check("wrap_count", 32'(xfer_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of the FIFO read data and the stream data.
REQ-002 Parameter CNT_W, default 16: width of the transferred-byte counter.
REQ-003 clk_read  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the clk_read rising edge.
REQ-005 fifo_data_out  input  DATA_W  FIFO read data, registered by the FIFO one cycle after the read strobe.
REQ-006 fifo_empty  input  1  FIFO empty flag.
REQ-007 fifo_read_enable  output  1  FIFO read strobe, one pop per asserted cycle.
REQ-008 m_data  output  DATA_W  stream data.
REQ-009 m_valid  output  1  stream data valid.
REQ-010 m_ready  input  1  downstream accept; a transfer occurs when m_valid && m_ready.
REQ-011 enable  input  1  drain enable; when low, no new reads are issued.
REQ-012 xfer_count  output  CNT_W  count of completed stream transfers; wraps modulo 2^CNT_W.
REQ-013 busy  output  1  high while any read is in flight or any skid entry is occupied.

Function
REQ-014 The block SHALL hold a 2-entry skid buffer (FIFO order) between the FIFO and the stream port.
REQ-015 Read latency: a strobe in cycle N SHALL capture fifo_data_out at the end of cycle N+1 into the skid buffer.
REQ-016 fifo_read_enable SHALL be asserted only when enable=1, fifo_empty=0, and (skid occupancy + reads in flight) < 2, counted after this cycle's departing transfer.
REQ-017 fifo_read_enable SHALL never be asserted while fifo_empty=1 (no underflow).
REQ-018 m_valid SHALL equal "skid occupancy > 0"; m_data SHALL present the oldest entry.
REQ-019 m_data and m_valid SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 A capture and a transfer in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-021 Sustained throughput: with fifo_empty=0, enable=1, and m_ready=1, one transfer per cycle after a 2-cycle fill latency.
REQ-022 FSM states:
  - IDLE: occupancy 0, nothing in flight.
  - STREAM: occupancy 1, or a read in flight.
  - FULL: occupancy 2; no reads issued.
REQ-023 FSM transitions SHALL follow occupancy and in-flight status each cycle; FULL SHALL exit to STREAM on the first transfer.
REQ-024 Deasserting enable SHALL stop new reads only; data in flight and data buffered SHALL still be delivered.
REQ-025 xfer_count SHALL increment by 1 on each transfer; rollover from 2^CNT_W-1 to 0.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst=0 at a clock edge:
  - occupancy, in-flight flag and xfer_count SHALL clear to 0;
  - state SHALL go to IDLE;
  - m_data SHALL clear to 0;
  - m_valid, fifo_read_enable and busy SHALL be 0 in the following cycle.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight data; no fifo_read_enable SHALL be asserted in the first cycle after reset release.

Configuration
REQ-029 Macro FIFO_READ_PARITY_EN:
  - when defined, the block SHALL add output m_parity (1 bit), the even parity (XOR) of m_data, stored per skid entry and stable with m_data;
  - when undefined, the port and its logic SHALL be absent, with identical behaviour otherwise.

Structure
REQ-030 A shared package fifo_read_pkg SHALL hold the FSM state enum (IDLE, STREAM, FULL) and the skid depth constant SKID_DEPTH=2.
REQ-031 The skid buffer SHALL be a sub-module fifo_read_skid (push/pop/occupancy); the FSM and counter stay in the top module.

Verification
REQ-032 Reset: rst=0 for 2 cycles with fifo_empty=0 and enable=1 -> m_valid=0, fifo_read_enable=0, xfer_count=0; first read strobe no earlier than the 2nd cycle after release.
REQ-033 Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> m_data sequence 0x01..0x10, one per cycle after fill, xfer_count=16.
REQ-034 Backpressure: m_ready=0 for 10 cycles mid-stream -> exactly 2 entries buffered, fifo_read_enable=0, m_data held; order preserved after release.
REQ-035 Empty boundary: FIFO with 1 entry (0xA5) -> exactly one strobe, m_data=0xA5, fifo_read_enable never high while fifo_empty=1.
REQ-036 Enable drop and wrap: enable low with a read in flight -> that byte is still delivered, then no strobes; xfer_count preset near 0xFFFF plus 2 transfers -> 0x0000 then 0x0001.
REQ-037 Parity build: with FIFO_READ_PARITY_EN, m_data=0x07 -> m_parity=1, m_data=0x03 -> m_parity=0.
